cache_refill_ctrl: RTL and testbench

- Sequences a line fill for the 4-way, 128-set, 64-byte-block cache: optional write-back of a dirty victim line, then an 8-beat fetch of the missing line from main memory.
- Drives the cache bank write port and the tag/state update for the chosen way.
- Sits between the cache control FSM (miss source) and the main-memory port, one word per handshake.

---
 rtl/cache_refill_ctrl.sv | 149 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Line-fill sequencer for the 4-way, 128-set, 64-byte-block cache.
// Optionally writes back a dirty victim line, then fetches the missing
// line one word per memory beat. It drives the bank write port and the
// tag/state update for the chosen way.
//
// Memory handshake (req/ack): mem_req is the valid. While it is high,
// mem_we and mem_addr (and mem_wdata for writes) are held stable. A beat
// completes on a rising edge where mem_req and mem_ack are both high.
// Read data is taken in that same cycle. mem_ack with mem_req low is
// ignored, and any number of wait cycles is allowed.
module cache_refill_ctrl #(
    parameter int ADDR_W = 20,
    parameter int TAG_W  = 7,
    parameter int IDX_W  = 7,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     miss_req,
    input  logic [ADDR_W-1:0]        miss_addr,
    input  logic [1:0]               victim_way,
    input  logic                     victim_dirty,
    input  logic [TAG_W-1:0]         victim_tag,
    output logic                     fill_busy,
    output logic                     fill_done,
    output logic [$clog2(BEATS)-1:0] wb_word_sel,
    input  logic [DATA_W-1:0]        wb_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     fill_we,
    output logic [1:0]               fill_way,
    output logic [IDX_W-1:0]         fill_index,
    output logic [$clog2(BEATS)-1:0] fill_word_sel,
    output logic [DATA_W-1:0]        fill_wdata,
    output logic                     tag_we,
    output logic [TAG_W-1:0]         tag_out,
    output logic [15:0]              fill_cnt
);

    localparam int BEAT_W = $clog2(BEATS);
    // Bits below the set index: word select plus byte-in-word.
    localparam int OFF_W  = BEAT_W + 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB      = 3'd1,
        FILL    = 3'd2,
        TAG_UPD = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state;
    logic [BEAT_W-1:0]  beat;
    logic [TAG_W-1:0]   vtag_q;
    logic [TAG_W-1:0]   addr_tag;

    // The byte offset and word field of the miss address are ignored,
    // because fills are always whole-block and start at word 0.
    logic unused_offset;
    assign unused_offset = ^miss_addr[OFF_W-1:0];

    // Decode the busy flag, the victim read select and the beat address from registers.
    assign fill_busy   = (state != IDLE);
    assign wb_word_sel = (state == WB) ? beat : '0;
    assign addr_tag    = mem_we ? vtag_q : tag_out;
    assign mem_addr    = mem_req ? {addr_tag, fill_index, beat, 3'b000} : '0;
    assign mem_wdata   = (mem_req && mem_we) ? wb_rdata : '0;

    // Main sequencer. All strobes are registered here; the latched tag, set
    // and way also serve as the tag_out, fill_index and fill_way outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            beat          <= '0;
            vtag_q        <= '0;
            tag_out       <= '0;
            fill_index    <= '0;
            fill_way      <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            fill_we       <= 1'b0;
            fill_word_sel <= '0;
            fill_wdata    <= '0;
            tag_we        <= 1'b0;
            fill_done     <= 1'b0;
            fill_cnt      <= '0;
        end else begin
            fill_we   <= 1'b0;
            tag_we    <= 1'b0;
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        tag_out    <= miss_addr[ADDR_W-1 -: TAG_W];
                        fill_index <= miss_addr[OFF_W +: IDX_W];
                        fill_way   <= victim_way;
                        vtag_q     <= victim_tag;
                        beat       <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= victim_dirty;
                        state      <= victim_dirty ? WB : FILL;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            mem_we <= 1'b0;
                            state  <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        fill_we       <= 1'b1;
                        fill_wdata    <= mem_rdata;
                        fill_word_sel <= beat;
                        beat          <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            mem_req <= 1'b0;
                            tag_we  <= 1'b1;
                            state   <= TAG_UPD;
                        end
                    end
                end
                TAG_UPD: begin
                    fill_done <= 1'b1;
                    if (fill_cnt != 16'hFFFF) begin
                        fill_cnt <= fill_cnt + 16'd1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl. It includes a memory responder
// with a configurable number of wait cycles and a modelled victim read port.
// Expected beats, fill writes and tag updates are queued when each fill is
// requested, and are checked as the design produces them.
module tb_cache_refill_ctrl;

    logic        clk;
    logic        rst_b;
    logic        miss_req;
    logic [19:0] miss_addr;
    logic [1:0]  victim_way;
    logic        victim_dirty;
    logic [6:0]  victim_tag;
    logic        fill_busy;
    logic        fill_done;
    logic [2:0]  wb_word_sel;
    logic [63:0] wb_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        fill_we;
    logic [1:0]  fill_way;
    logic [6:0]  fill_index;
    logic [2:0]  fill_word_sel;
    logic [63:0] fill_wdata;
    logic        tag_we;
    logic [6:0]  tag_out;
    logic [15:0] fill_cnt;

    cache_refill_ctrl dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .miss_req      (miss_req),
        .miss_addr     (miss_addr),
        .victim_way    (victim_way),
        .victim_dirty  (victim_dirty),
        .victim_tag    (victim_tag),
        .fill_busy     (fill_busy),
        .fill_done     (fill_done),
        .wb_word_sel   (wb_word_sel),
        .wb_rdata      (wb_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .fill_we       (fill_we),
        .fill_way      (fill_way),
        .fill_index    (fill_index),
        .fill_word_sel (fill_word_sel),
        .fill_wdata    (fill_wdata),
        .tag_we        (tag_we),
        .tag_out       (tag_out),
        .fill_cnt      (fill_cnt)
    );

    // Clock generation: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [84:0] mem_q[$];   // {we, addr[19:0], wdata[63:0]}
    logic [75:0] fill_q[$];  // {way, index, word, data}
    logic [15:0] tag_q[$];   // {way, index, tag}
    logic [31:0] vseed;
    logic [63:0] rbase;
    int          mem_waits;
    logic [15:0] exp_cnt;

    // Victim read port model: the word is tagged with a per-test seed and its index.
    assign wb_rdata = {vseed, 29'd0, wb_word_sel};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected beats, fill writes and tag update for one fill.
    task automatic push_exp(input logic [19:0] addr, input logic [1:0] way,
                            input logic dirty, input logic [6:0] vtag);
        logic [6:0] tg;
        logic [6:0] ix;
        tg = addr[19:13];
        ix = addr[12:6];
        if (dirty) begin
            for (int k = 0; k < 8; k++)
                mem_q.push_back({1'b1, vtag, ix, 3'(k), 3'b000, vseed, 29'd0, 3'(k)});
        end
        for (int k = 0; k < 8; k++)
            mem_q.push_back({1'b0, tg, ix, 3'(k), 3'b000, 64'd0});
        for (int k = 0; k < 8; k++)
            fill_q.push_back({way, ix, 3'(k), rbase + 64'(k)});
        tag_q.push_back({way, ix, tg});
    endtask

    // Memory responder: it acks after mem_waits idle cycles and returns rbase + word.
    // While no request is pending, it drives random stray acks.
    initial begin : mem_model
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (wcnt >= mem_waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rbase + 64'(mem_addr[5:3]);
                    wcnt      = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    wcnt++;
                end
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
                wcnt      = 0;
            end
        end
    end

    // Scoreboard monitor, which samples between clock edges.
    initial begin : monitor
        logic [84:0] me;
        logic [75:0] fe;
        logic [15:0] te;
        logic        prev_wait;
        logic        prev_we;
        logic [19:0] prev_addr;
        prev_wait = 1'b0;
        prev_we   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_b) begin
                if (prev_wait)
                    check("req_held", {mem_req, mem_we, mem_addr}, {1'b1, prev_we, prev_addr});
                prev_wait = mem_req && !mem_ack;
                prev_we   = mem_we;
                prev_addr = mem_addr;
                if (mem_req && mem_ack) begin
                    check("mem_beat_expected", 128'(mem_q.size() != 0), 128'd1);
                    if (mem_q.size() != 0) begin
                        me = mem_q.pop_front();
                        check("mem_we", mem_we, me[84]);
                        check("mem_addr", mem_addr, me[83:64]);
                        if (me[84]) check("mem_wdata", mem_wdata, me[63:0]);
                    end
                end
                if (fill_we) begin
                    check("fill_we_expected", 128'(fill_q.size() != 0), 128'd1);
                    if (fill_q.size() != 0) begin
                        fe = fill_q.pop_front();
                        check("fill_target", {fill_way, fill_index, fill_word_sel}, fe[75:64]);
                        check("fill_wdata", fill_wdata, fe[63:0]);
                    end
                end
                if (tag_we) begin
                    check("tag_we_expected", 128'(tag_q.size() != 0), 128'd1);
                    if (tag_q.size() != 0) begin
                        te = tag_q.pop_front();
                        check("tag_update", {fill_way, fill_index, tag_out}, te);
                        check("tag_with_last_word", {fill_we, fill_word_sel}, {1'b1, 3'd7});
                    end
                end
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    // Run one fill: request it, then count cycles after the accept edge until fill_done.
    task automatic do_fill(input logic [19:0] addr, input logic [1:0] way, input logic dirty,
                           input logic [6:0] vtag, input int waits, input int exp_cyc,
                           input bit scramble, input bit hold_end, input string name);
        int n;
        bit done;
        mem_waits = waits;
        push_exp(addr, way, dirty, vtag);
        @(negedge clk);
        #2;
        miss_req     = 1'b1;
        miss_addr    = addr;
        victim_way   = way;
        victim_dirty = dirty;
        victim_tag   = vtag;
        @(posedge clk);
        n    = 0;
        done = 1'b0;
        while (!done && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
            if (fill_done) begin
                done     = 1'b1;
                miss_req = hold_end;
            end else if (scramble) begin
                miss_req     = 1'($urandom_range(0, 1));
                miss_addr    = 20'($urandom);
                victim_way   = 2'($urandom_range(0, 3));
                victim_dirty = 1'($urandom_range(0, 1));
                victim_tag   = 7'($urandom);
            end else begin
                miss_req = 1'b0;
            end
        end
        check({name, "_done_cycle"}, 128'(n), 128'(exp_cyc));
        check({name, "_busy_in_done"}, fill_busy, 1'b1);
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (!hold_end) begin
            @(negedge clk);
            #1;
            check({name, "_idle_after"}, {fill_busy, fill_done}, 2'b00);
            check({name, "_fill_cnt"}, fill_cnt, exp_cnt);
        end
    endtask

    // Directed sequence.
    initial begin : stimulus
        logic [19:0] raddr;
        int          rw;
        int          n;
        rst_b        = 1'b1;
        miss_req     = 1'b0;
        miss_addr    = '0;
        victim_way   = '0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        vseed        = '0;
        rbase        = '0;
        mem_waits    = 0;
        exp_cnt      = '0;
        #1 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {fill_busy, fill_done, wb_word_sel, mem_req, mem_we, mem_addr,
                             fill_we, fill_way, fill_index, fill_word_sel, tag_we, tag_out,
                             fill_cnt}, '0);
        check("reset_data", {mem_wdata, fill_wdata}, '0);
        @(negedge clk);
        #2 rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Clean miss, zero-wait memory: set 1, way 3, tag 0.
        rbase = 64'h1000;
        do_fill(20'h00078, 2'd3, 1'b0, 7'h00, 0, 10, 1'b0, 1'b0, "clean");

        // Dirty miss: write-back to 0xAA080.., then read set 2.
        vseed = 32'hC0DE_0055;
        rbase = 64'h2000;
        do_fill(20'h06080, 2'd1, 1'b1, 7'h55, 0, 18, 1'b0, 1'b0, "dirty");

        // Three wait cycles per beat.
        rbase = 64'h3000;
        do_fill(20'h1F5C7, 2'd0, 1'b0, 7'h12, 3, 34, 1'b0, 1'b0, "wait3");

        // Random address and wait count, dirty victim.
        raddr = 20'($urandom);
        rw    = $urandom_range(0, 2);
        vseed = 32'($urandom);
        rbase = {32'($urandom), 32'h0};
        do_fill(raddr, 2'($urandom_range(0, 3)), 1'b1, 7'($urandom), rw, 16 * (rw + 1) + 2,
                1'b0, 1'b0, "rand");

        // Reset asserted while FILL beat 4 is in flight.
        rbase     = 64'h4000;
        mem_waits = 0;
        push_exp(20'h00C40, 2'd1, 1'b0, 7'h00);
        @(negedge clk);
        #2;
        miss_req     = 1'b1;
        miss_addr    = 20'h00C40;
        victim_way   = 2'd1;
        victim_dirty = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            miss_req = 1'b0;
            n++;
        end while (!(mem_req && !mem_we && mem_addr[5:3] == 3'd4) && n < 100);
        check("rst_at_beat4", mem_addr, 20'h00C60);
        rst_b = 1'b0;
        #1;
        check("rst_async_ctrl", {fill_busy, fill_done, wb_word_sel, mem_req, mem_we, mem_addr,
                                 fill_we, fill_way, fill_index, fill_word_sel, tag_we, tag_out,
                                 fill_cnt}, '0);
        check("rst_async_data", {mem_wdata, fill_wdata}, '0);
        mem_q.delete();
        fill_q.delete();
        tag_q.delete();
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rst_idle_after", {fill_busy, mem_req, fill_cnt}, '0);
        rbase = 64'h5000;
        do_fill(20'h00C40, 2'd1, 1'b0, 7'h00, 0, 10, 1'b0, 1'b0, "post_rst");

        // Inputs scrambled while busy; miss_req held through DONE starts the next fill.
        vseed = 32'h0BAD_F00D;
        rbase = 64'h6000;
        do_fill(20'h0A5C0, 2'd2, 1'b1, 7'h33, 0, 18, 1'b1, 1'b1, "busy_toggle");
        rbase = 64'h7000;
        do_fill(20'h0E1C0, 2'd1, 1'b0, 7'h00, 0, 10, 1'b0, 1'b0, "held_second");

        // Saturation: preload the counter just below its limit.
        @(negedge clk);
        #2;
        force dut.fill_cnt = 16'hFFFE;
        #1;
        release dut.fill_cnt;
        exp_cnt = 16'hFFFE;
        #1;
        check("cnt_preload", fill_cnt, 16'hFFFE);
        rbase = 64'h8000;
        do_fill(20'h12340, 2'd0, 1'b0, 7'h00, 0, 10, 1'b0, 1'b0, "sat1");
        rbase = 64'h9000;
        do_fill(20'h54320, 2'd3, 1'b0, 7'h00, 1, 18, 1'b0, 1'b0, "sat2");

        repeat (3) @(negedge clk);
        check("mem_q_drained", 128'(mem_q.size()), 128'd0);
        check("fill_q_drained", 128'(fill_q.size()), 128'd0);
        check("tag_q_drained", 128'(tag_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
